// File: rtl/polyphase_interpolator_mc.sv
// rtl/polyphase_interpolator_mc.sv - multichannel polyphase interpolator, one time-shared MAC.
// Optional POLYPHASE_SATURATE_EN clamps the output instead of wrapping it.
module polyphase_interpolator_mc #(
   parameter int NUMBER_TAPS       = 32,
   parameter int RATE_CHANGE       = 8,
   parameter int NUM_CHANNELS      = 2,
   parameter int DATA_IN_WIDTH     = 16,
   parameter int DATA_OUT_WIDTH    = 16,
   parameter int COEFFICIENT_WIDTH = 16,
   parameter int OUTPUT_SHIFT      = 15,
   localparam int SUB_LENGTH = NUMBER_TAPS / RATE_CHANGE,
   localparam int CH_W       = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1,
   localparam int ADDR_W     = $clog2(NUMBER_TAPS)
) (
   input  logic                                aclk,
   input  logic                                aresetn,
   input  logic                                data_in_tvalid,
   output logic                                data_in_tready,
   input  logic signed [DATA_IN_WIDTH-1:0]     data_in_tdata,
   input  logic [CH_W-1:0]                     data_in_tid,
   input  logic                                data_in_tlast,
   output logic                                data_out_tvalid,
   input  logic                                data_out_tready,
   output logic [DATA_OUT_WIDTH-1:0]           data_out_tdata,
   output logic [CH_W-1:0]                     data_out_tid,
   output logic                                data_out_tlast,
   input  logic                                coeffs_wren,
   input  logic [ADDR_W-1:0]                   coeffs_addr,
   input  logic signed [COEFFICIENT_WIDTH-1:0] coeffs_wdata
);
   localparam int ACC_W  = DATA_IN_WIDTH + COEFFICIENT_WIDTH + $clog2(SUB_LENGTH) + 1;
   localparam int PROD_W = DATA_IN_WIDTH + COEFFICIENT_WIDTH;
   localparam int PH_W   = $clog2(RATE_CHANGE);
   localparam int JW     = (SUB_LENGTH > 1) ? $clog2(SUB_LENGTH) : 1;
   localparam int CNT_W  = $clog2(SUB_LENGTH + 2);
   localparam int FC_W   = $clog2(SUB_LENGTH + 1);

   typedef enum logic [1:0] {S_IDLE, S_MAC, S_OUT, S_FLUSH} state_t;

   state_t                        state_q, state_d;
   logic [PH_W-1:0]               phase_q, phase_d;
   logic [CNT_W-1:0]              cnt_q, cnt_d;
   logic [CH_W-1:0]               ch_q, ch_d;
   logic                          last_q, last_d;
   logic [FC_W-1:0]               flush_q, flush_d;
   logic signed [PROD_W-1:0]      prod_q, prod_d;
   logic signed [ACC_W-1:0]       acc_q, acc_d;
   logic [DATA_OUT_WIDTH-1:0]     tdata_q, tdata_d, out_val;
   logic                          tlast_q, tlast_d;
   logic                          tvalid_q, tready_q;
   logic signed [DATA_IN_WIDTH-1:0]     dl_q [NUM_CHANNELS][SUB_LENGTH];
   logic signed [COEFFICIENT_WIDTH-1:0] coef_q [NUMBER_TAPS];
   logic                          shift_en, tid_ok, accept;
   logic [CH_W-1:0]               shift_ch;
   logic signed [DATA_IN_WIDTH-1:0] shift_val;
   logic [JW-1:0]                 j_idx;
   logic [ADDR_W-1:0]             rd_addr;

   generate
      if (NUM_CHANNELS == (1 << CH_W)) begin : g_tid_full
         assign tid_ok = 1'b1;
      end else begin : g_tid_chk
         assign tid_ok = ({1'b0, data_in_tid} < NUM_CHANNELS[CH_W:0]);
      end
   endgenerate

   assign accept  = data_in_tvalid & tready_q;
   assign j_idx   = cnt_q[JW-1:0];
   assign rd_addr = ADDR_W'({j_idx, phase_q});

`ifdef POLYPHASE_SATURATE_EN
   localparam logic signed [ACC_W-1:0] OUT_MAX =
      {{(ACC_W-DATA_OUT_WIDTH+1){1'b0}}, {(DATA_OUT_WIDTH-1){1'b1}}};
   localparam logic signed [ACC_W-1:0] OUT_MIN =
      {{(ACC_W-DATA_OUT_WIDTH+1){1'b1}}, {(DATA_OUT_WIDTH-1){1'b0}}};
   logic signed [ACC_W-1:0] shifted;
   assign shifted = acc_q >>> OUTPUT_SHIFT;
   assign out_val = (shifted > OUT_MAX) ? OUT_MAX[DATA_OUT_WIDTH-1:0] :
                    (shifted < OUT_MIN) ? OUT_MIN[DATA_OUT_WIDTH-1:0] :
                    shifted[DATA_OUT_WIDTH-1:0];
`else
   assign out_val = DATA_OUT_WIDTH'(acc_q >>> OUTPUT_SHIFT);
`endif

   // Coefficient RAM survives reset; a same-cycle read sees the old word.
   always_ff @(posedge aclk) begin
      if (coeffs_wren) coef_q[coeffs_addr] <= coeffs_wdata;
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         for (int c = 0; c < NUM_CHANNELS; c++)
            for (int j = 0; j < SUB_LENGTH; j++) dl_q[c][j] <= '0;
      end else if (shift_en) begin
         dl_q[shift_ch][0] <= shift_val;
         for (int j = 1; j < SUB_LENGTH; j++) dl_q[shift_ch][j] <= dl_q[shift_ch][j-1];
      end
   end

   always_comb begin
      prod_d = '0;
      if (state_q == S_MAC && cnt_q < CNT_W'(SUB_LENGTH))
         prod_d = dl_q[ch_q][j_idx] * coef_q[rd_addr];
   end

   always_comb begin
      state_d   = state_q;
      phase_d   = phase_q;
      cnt_d     = cnt_q;
      ch_d      = ch_q;
      last_d    = last_q;
      flush_d   = flush_q;
      acc_d     = acc_q;
      tdata_d   = tdata_q;
      tlast_d   = tlast_q;
      shift_en  = 1'b0;
      shift_ch  = ch_q;
      shift_val = '0;
      case (state_q)
         S_IDLE: begin
            if (accept && tid_ok) begin
               shift_en  = 1'b1;
               shift_ch  = data_in_tid;
               shift_val = data_in_tdata;
               ch_d      = data_in_tid;
               last_d    = data_in_tlast;
               flush_d   = data_in_tlast ? FC_W'(SUB_LENGTH - 1) : '0;
               phase_d   = '0;
               cnt_d     = '0;
               state_d   = S_MAC;
            end
         end
         S_MAC: begin
            // Products lag one cycle behind the tap index, so the sum completes at cnt==SUB_LENGTH.
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == '0) acc_d = '0;
            else if (cnt_q <= CNT_W'(SUB_LENGTH))
               acc_d = acc_q + {{(ACC_W-PROD_W){prod_q[PROD_W-1]}}, prod_q};
            if (cnt_q == CNT_W'(SUB_LENGTH + 1)) begin
               tdata_d = out_val;
               tlast_d = last_q && (flush_q == '0) && (phase_q == PH_W'(RATE_CHANGE - 1));
               state_d = S_OUT;
            end
         end
         S_OUT: begin
            if (data_out_tready) begin
               tlast_d = 1'b0;
               if (phase_q != PH_W'(RATE_CHANGE - 1)) begin
                  phase_d = phase_q + 1'b1;
                  cnt_d   = '0;
                  state_d = S_MAC;
               end else if (flush_q != '0) begin
                  state_d = S_FLUSH;
               end else begin
                  state_d = S_IDLE;
               end
            end
         end
         S_FLUSH: begin
            shift_en = 1'b1;
            flush_d  = flush_q - 1'b1;
            phase_d  = '0;
            cnt_d    = '0;
            state_d  = S_MAC;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state_q  <= S_IDLE;
         phase_q  <= '0;
         cnt_q    <= '0;
         ch_q     <= '0;
         last_q   <= 1'b0;
         flush_q  <= '0;
         prod_q   <= '0;
         acc_q    <= '0;
         tdata_q  <= '0;
         tlast_q  <= 1'b0;
         tvalid_q <= 1'b0;
         tready_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         phase_q  <= phase_d;
         cnt_q    <= cnt_d;
         ch_q     <= ch_d;
         last_q   <= last_d;
         flush_q  <= flush_d;
         prod_q   <= prod_d;
         acc_q    <= acc_d;
         tdata_q  <= tdata_d;
         tlast_q  <= tlast_d;
         tvalid_q <= (state_d == S_OUT);
         tready_q <= (state_d == S_IDLE);
      end
   end

   assign data_in_tready  = tready_q;
   assign data_out_tvalid = tvalid_q;
   assign data_out_tdata  = tdata_q;
   assign data_out_tid    = ch_q;
   assign data_out_tlast  = tlast_q;

endmodule

// File: tb/tb_polyphase_interpolator_mc.sv
// tb/tb_polyphase_interpolator_mc.sv - scoreboard bench for polyphase_interpolator_mc.
module tb_polyphase_interpolator_mc;
   localparam int R  = 8;
   localparam int NT = 32;
   localparam int S  = NT / R;

   logic        aclk, aresetn;
   logic        data_in_tvalid, data_in_tready, data_in_tlast;
   logic [15:0] data_in_tdata;
   logic [0:0]  data_in_tid;
   logic        data_out_tvalid, data_out_tready, data_out_tlast;
   logic [15:0] data_out_tdata;
   logic [0:0]  data_out_tid;
   logic        coeffs_wren;
   logic [4:0]  coeffs_addr;
   logic [15:0] coeffs_wdata;

   polyphase_interpolator_mc dut (
      .aclk(aclk), .aresetn(aresetn),
      .data_in_tvalid(data_in_tvalid), .data_in_tready(data_in_tready),
      .data_in_tdata(data_in_tdata), .data_in_tid(data_in_tid), .data_in_tlast(data_in_tlast),
      .data_out_tvalid(data_out_tvalid), .data_out_tready(data_out_tready),
      .data_out_tdata(data_out_tdata), .data_out_tid(data_out_tid), .data_out_tlast(data_out_tlast),
      .coeffs_wren(coeffs_wren), .coeffs_addr(coeffs_addr), .coeffs_wdata(coeffs_wdata)
   );

   typedef struct {logic [15:0] d; logic tid; logic last;} exp_t;
   exp_t sb[$];
   longint h_m [NT];
   longint x_m [2][S];
   int checks = 0, errors = 0, tlast_cnt = 0;
   bit bp_low = 0, bp_rand = 0;

   initial begin
      aclk = 0;
      forever #5 aclk = ~aclk;
   end

   initial begin
      data_out_tready = 1;
      forever begin
         @(posedge aclk); #1;
         data_out_tready = bp_low ? 1'b0 : (bp_rand ? ($urandom_range(0, 3) != 0) : 1'b1);
      end
   end

   function automatic logic [15:0] fmt(input longint acc);
      longint s;
      logic [15:0] r;
      s = acc >>> 15;
`ifdef POLYPHASE_SATURATE_EN
      if (s > 32767) s = 32767;
      if (s < -32768) s = -32768;
`endif
      r = s[15:0];
      return r;
   endfunction

   // Reference: each accepted sample (plus flush zeros) yields R outputs y[p]=sum_j x[j]*h[j*R+p].
   function automatic void model_sample(input int ch, input longint d, input bit last);
      int nf;
      longint acc, v;
      exp_t e;
      nf = last ? S - 1 : 0;
      for (int k = 0; k <= nf; k++) begin
         v = (k == 0) ? d : 0;
         for (int j = S - 1; j > 0; j--) x_m[ch][j] = x_m[ch][j-1];
         x_m[ch][0] = v;
         for (int p = 0; p < R; p++) begin
            acc = 0;
            for (int j = 0; j < S; j++) acc += x_m[ch][j] * h_m[j*R + p];
            e.d = fmt(acc);
            e.tid = ch[0];
            e.last = last && (k == nf) && (p == R - 1);
            sb.push_back(e);
         end
      end
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic write_coef(input int addr, input logic [15:0] val);
      @(negedge aclk);
      coeffs_wren = 1; coeffs_addr = 5'(addr); coeffs_wdata = val;
      @(posedge aclk); #1;
      coeffs_wren = 0;
      h_m[addr] = longint'($signed(val));
   endtask

   task automatic send(input logic [15:0] d, input int ch, input bit last);
      int n;
      bit done;
      n = 0; done = 0;
      data_in_tdata = d; data_in_tid = ch[0]; data_in_tlast = last; data_in_tvalid = 1;
      while (!done && n < 2000) begin
         @(negedge aclk);
         n++;
         if (data_in_tready) begin
            @(posedge aclk); #1;
            done = 1;
         end
      end
      data_in_tvalid = 0; data_in_tlast = 0;
      if (done) model_sample(ch, longint'($signed(d)), last);
      else chk("send_timeout", 1, 0);
   endtask

   task automatic wait_drain();
      int n;
      n = 0;
      while ((sb.size() != 0 || !data_in_tready) && n < 20000) begin
         @(posedge aclk); #1;
         n++;
      end
      chk("drain_done", (sb.size() == 0 && data_in_tready) ? 1 : 0, 1);
   endtask

   task automatic load_impulse_coefs();
      for (int k = 0; k < NT; k++) write_coef(k, 16'((k + 1) << 10));
   endtask

   logic        hold_v = 0;
   logic [15:0] hold_d;
   logic        hold_tid, hold_last;
   exp_t        got;

   always @(negedge aclk) begin
      if (!aresetn) hold_v = 0;
      else begin
         if (hold_v) begin
            checks++;
            if (!data_out_tvalid || data_out_tdata !== hold_d || data_out_tid !== hold_tid ||
                data_out_tlast !== hold_last) begin
               errors++;
               $display("FAIL hold_stable: got v=%0b d=%0h tid=%0d last=%0b expected d=%0h tid=%0d last=%0b",
                        data_out_tvalid, data_out_tdata, data_out_tid, data_out_tlast, hold_d, hold_tid, hold_last);
            end
         end
         if (data_out_tvalid) begin
            checks++;
            if (data_in_tready !== 1'b0) begin
               errors++;
               $display("FAIL in_tready_busy: got %0b expected 0", data_in_tready);
            end
         end
         if (data_out_tvalid && data_out_tready) begin
            hold_v = 0;
            if (data_out_tlast) tlast_cnt++;
            checks++;
            if (sb.size() == 0) begin
               errors++;
               $display("FAIL unexpected_output: got d=%0h tid=%0d expected none", data_out_tdata, data_out_tid);
            end else begin
               got = sb.pop_front();
               if (data_out_tdata !== got.d || data_out_tid !== got.tid || data_out_tlast !== got.last) begin
                  errors++;
                  $display("FAIL output: got d=%0h tid=%0d last=%0b expected d=%0h tid=%0d last=%0b",
                           data_out_tdata, data_out_tid, data_out_tlast, got.d, got.tid, got.last);
               end
            end
         end else if (data_out_tvalid) begin
            hold_v = 1; hold_d = data_out_tdata; hold_tid = data_out_tid; hold_last = data_out_tlast;
         end else hold_v = 0;
      end
   end

   initial begin
      int n, t0;
      aresetn = 0; data_in_tvalid = 0; data_in_tdata = 0; data_in_tid = 0; data_in_tlast = 0;
      coeffs_wren = 0; coeffs_addr = 0; coeffs_wdata = 0;
      for (int c = 0; c < 2; c++) for (int j = 0; j < S; j++) x_m[c][j] = 0;
      repeat (3) @(posedge aclk); #1;
      chk("rst_out_tvalid", data_out_tvalid, 0);
      chk("rst_in_tready", data_in_tready, 0);
      chk("rst_out_tdata", data_out_tdata, 0);
      chk("rst_out_tlast", data_out_tlast, 0);
      chk("rst_out_tid", data_out_tid, 0);
      aresetn = 1;
      load_impulse_coefs();

      // impulse plus first-output latency
      send(16'd32, 0, 0);
      n = 0;
      while (!data_out_tvalid && n < 100) begin @(posedge aclk); #1; n++; end
      chk("first_latency", n, S + 2);
      for (int i = 0; i < 3; i++) send(16'd0, 0, 0);
      wait_drain();

      // isolation: ch0 impulse interleaved with ch1 zeros
      for (int i = 0; i < 4; i++) begin
         send((i == 0) ? 16'd32 : 16'd0, 0, 0);
         send(16'd0, 1, 0);
      end
      wait_drain();

      // backpressure window of 20 cycles during OUT
      send(16'd32, 0, 0);
      n = 0;
      while (!data_out_tvalid && n < 100) begin @(posedge aclk); #1; n++; end
      bp_low = 1;
      repeat (20) @(posedge aclk);
      #1;
      chk("bp_valid_held", data_out_tvalid, 1);
      bp_low = 0;
      for (int i = 0; i < 3; i++) send(16'd0, 0, 0);
      wait_drain();

      // flush bursts
      t0 = tlast_cnt;
      send(16'd32, 0, 1);
      wait_drain();
      chk("flush_tlast_count", tlast_cnt - t0, 1);
      send(16'd32, 0, 1);
      wait_drain();
      chk("flush_repeat_tlast", tlast_cnt - t0, 2);

      // randomized coefficients, samples, channels, tlast and backpressure
      bp_rand = 1;
      for (int k = 0; k < NT; k++) write_coef(k, 16'($urandom));
      for (int i = 0; i < 60; i++)
         send(16'($urandom), int'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0));
      wait_drain();
      bp_rand = 0;

      // reset during MAC keeps coefficients
      load_impulse_coefs();
      send(16'd32, 1, 0);
      repeat (2) @(posedge aclk);
      #1;
      aresetn = 0;
      #1;
      chk("midrst_out_tvalid", data_out_tvalid, 0);
      chk("midrst_in_tready", data_in_tready, 0);
      sb.delete();
      for (int c = 0; c < 2; c++) for (int j = 0; j < S; j++) x_m[c][j] = 0;
      repeat (2) @(posedge aclk);
      #1;
      aresetn = 1;
      send(16'd32, 0, 0);
      for (int i = 0; i < 3; i++) send(16'd0, 0, 0);
      wait_drain();

      // overflow: full-scale coefficients and input
      for (int k = 0; k < NT; k++) write_coef(k, 16'h7FFF);
      for (int i = 0; i < 4; i++) send(16'h7FFF, 1, 0);
      wait_drain();

      chk("scoreboard_empty", sb.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
